// File: rtl/ram_pkg.sv
// Shared constants and types for the simple-dual-port RAM and its clear sequencer.
// Read-during-write mode codes, legal read latencies, and the init FSM state type.
// Pure declarations; no logic.
package ram_pkg;

   localparam int RDW_OLD    = 0;
   localparam int RDW_NEW    = 1;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_init_state_t;

   function automatic bit rd_lat_legal(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Post-reset zero-clear sequencer: walks every address once, then reports ready.
// Sweep takes exactly DEPTH cycles after reset release; init_done rises the cycle after the last clear write.
// No backpressure: the sweep always runs to completion unless reset restarts it.
module ram_clear_fsm
   import ram_pkg::*;
#(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] o_clr_addr,
   output logic              o_clr_we,
   output logic              o_init_done
);

   localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

   ram_init_state_t   r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_clr_we;
   logic              r_init_done;

   // Sweep addresses 0..DEPTH-1 while in CLEAR, then park in READY until the next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= CLEAR;
         r_cnt       <= '0;
         r_clr_we    <= 1'b1;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               if (r_cnt == C_LAST) begin
                  r_state     <= READY;
                  r_clr_we    <= 1'b0;
                  r_init_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            READY: begin
               r_state <= READY;
            end
            default: begin
               r_state <= CLEAR;
            end
         endcase
      end
   end

   assign o_clr_addr  = r_cnt;
   assign o_clr_we    = r_clr_we;
   assign o_init_done = r_init_done;

endmodule

// File: rtl/ram_sdp.sv
// Simple-dual-port RAM with byte-enable writes, 1- or 2-cycle registered reads and selectable read-during-write.
// Read latency RD_LAT cycles from rd_val to rd_data_val; writes visible to a read on the next cycle.
// No backpressure: accepts one read and one write per cycle once init_done is high, ignores requests before.
module ram_sdp
   import ram_pkg::*;
#(
   parameter int DATA_W   = 4096,
   parameter int DEPTH    = 128,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = RDW_OLD
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_val,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic                rd_val,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_data_val,
   output logic                init_done
);

   localparam int NB = DATA_W / 8;

   // Reject illegal configurations at elaboration.
   if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("ram_sdp: DATA_W must be a multiple of 8");
   end
   if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("ram_sdp: RD_LAT must be 1 or 2");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("ram_sdp: DEPTH must be at least 2");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_clr_we;
   logic              w_init_done;
   logic              w_wr_inrng;
   logic              w_rd_inrng;
   logic              w_usr_we;
   logic              w_rd_acc;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [NB-1:0]     w_be;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] w_rd_next;
   logic              r_s1_vld;
   logic [DATA_W-1:0] r_s1_dat;

   ram_clear_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk         (clk),
      .rst         (rst),
      .o_clr_addr  (w_clr_addr),
      .o_clr_we    (w_clr_we),
      .o_init_done (w_init_done)
   );

   // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
   if ((2 ** ADDR_W) == DEPTH) begin : g_pow2
      assign w_wr_inrng = 1'b1;
      assign w_rd_inrng = 1'b1;
   end else begin : g_npow2
      localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
      assign w_wr_inrng = ({1'b0, wr_addr} < C_DEPTH);
      assign w_rd_inrng = ({1'b0, rd_addr} < C_DEPTH);
   end

   // User requests count only once the sweep is done; out-of-range writes are dropped.
   assign w_usr_we = w_init_done & wr_val & w_wr_inrng & ~rst;
   assign w_rd_acc = w_init_done & rd_val & ~rst;

   // The clear sweep owns the write port until init_done; the two never overlap.
   assign w_we    = (w_clr_we & ~rst) | w_usr_we;
   assign w_addr  = w_clr_we ? w_clr_addr : wr_addr;
   assign w_be    = w_clr_we ? {NB{1'b1}} : wr_be;
   assign w_wdata = w_clr_we ? '0 : wr_data;

   // Byte-masked array write.
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < NB; b++) begin
            if (w_be[b]) begin
               r_mem[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   // Array read sees pre-write contents; out-of-range reads return zero.
   assign w_rd_word = w_rd_inrng ? r_mem[rd_addr] : '0;

   // New-data mode forwards the enabled bytes of a same-address write into the read.
   if (RDW_MODE == RDW_NEW) begin : g_rdw_new
      logic w_coll;
      assign w_coll = w_usr_we & (wr_addr == rd_addr);
      for (genvar b = 0; b < NB; b++) begin : g_byte
         assign w_rd_next[8*b +: 8] = (w_coll & wr_be[b]) ? wr_data[8*b +: 8]
                                                           : w_rd_word[8*b +: 8];
      end
   end else begin : g_rdw_old
      assign w_rd_next = w_rd_word;
   end

   // Stage 1: registered array read; data holds when no read is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_dat <= '0;
      end else begin
         r_s1_vld <= w_rd_acc;
         if (w_rd_acc) begin
            r_s1_dat <= w_rd_next;
         end
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic              r_s2_vld;
      logic [DATA_W-1:0] r_s2_dat;

      // Stage 2: extra output register, loaded only when stage 1 carries a read.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
         end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
               r_s2_dat <= r_s1_dat;
            end
         end
      end

      assign rd_data     = r_s2_dat;
      assign rd_data_val = r_s2_vld;
   end else begin : g_lat1
      assign rd_data     = r_s1_dat;
      assign rd_data_val = r_s1_vld;
   end

   assign init_done = w_init_done;

endmodule

// File: tb/tb_ram_sdp.sv
// Self-checking bench for ram_sdp: two instances driven by the same stimulus.
// Instance A: DEPTH=128, RD_LAT=1, old-data collisions. Instance B: DEPTH=100, RD_LAT=2, new-data collisions.
// Expected reads are pushed to per-instance queues at drive time and popped when rd_data_val appears.
module tb_ram_sdp;

   localparam int DW = 64;
   localparam int NB = DW / 8;
   localparam int AW = 7;
   localparam int DEPTH_A = 128;
   localparam int DEPTH_B = 100;

   typedef struct {
      logic [DW-1:0] dat;
      int            due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_val = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [NB-1:0] wr_be = '0;
   logic          rd_val = 1'b0;
   logic [AW-1:0] rd_addr = '0;

   logic [DW-1:0] a_rd_data, b_rd_data;
   logic          a_rd_vld, b_rd_vld;
   logic          a_init, b_init;

   exp_t          qa[$];
   exp_t          qb[$];
   logic [DW-1:0] mem_a [DEPTH_A];
   logic [DW-1:0] mem_b [DEPTH_B];
   bit            rdy_a = 1'b0;
   bit            rdy_b = 1'b0;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ram_sdp #(
      .DATA_W   (DW),
      .DEPTH    (DEPTH_A),
      .RD_LAT   (1),
      .RDW_MODE (0)
   ) u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .wr_val      (wr_val),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .rd_val      (rd_val),
      .rd_addr     (rd_addr),
      .rd_data     (a_rd_data),
      .rd_data_val (a_rd_vld),
      .init_done   (a_init)
   );

   ram_sdp #(
      .DATA_W   (DW),
      .DEPTH    (DEPTH_B),
      .RD_LAT   (2),
      .RDW_MODE (1)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .wr_val      (wr_val),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .rd_val      (rd_val),
      .rd_addr     (rd_addr),
      .rd_data     (b_rd_data),
      .rd_data_val (b_rd_vld),
      .init_done   (b_init)
   );

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and advance the reference model.
   task automatic drive(input logic r, input logic wv, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [NB-1:0] be,
                        input logic rv, input logic [AW-1:0] ra);
      logic [DW-1:0] d;
      @(negedge clk);
      rst     = r;
      wr_val  = wv;
      wr_addr = wa;
      wr_data = wd;
      wr_be   = be;
      rd_val  = rv;
      rd_addr = ra;
      if (r) begin
         rdy_a = 1'b0;
         rdy_b = 1'b0;
         while (qa.size() > 0 && qa[$].due > cyc) void'(qa.pop_back());
         while (qb.size() > 0 && qb[$].due > cyc) void'(qb.pop_back());
      end else begin
         if (rdy_a) begin
            if (rv) qa.push_back('{dat: mem_a[ra], due: cyc + 1});
            if (wv) begin
               for (int b = 0; b < NB; b++)
                  if (be[b]) mem_a[wa][8*b +: 8] = wd[8*b +: 8];
            end
         end
         if (rdy_b) begin
            if (rv) begin
               d = (int'(ra) < DEPTH_B) ? mem_b[ra] : '0;
               if (wv && wa == ra && int'(ra) < DEPTH_B) begin
                  for (int b = 0; b < NB; b++)
                     if (be[b]) d[8*b +: 8] = wd[8*b +: 8];
               end
               qb.push_back('{dat: d, due: cyc + 2});
            end
            if (wv && int'(wa) < DEPTH_B) begin
               for (int b = 0; b < NB; b++)
                  if (be[b]) mem_b[wa][8*b +: 8] = wd[8*b +: 8];
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   // Release reset, hammer the ports with requests that must be ignored, and time init_done.
   task automatic wait_init();
      int ka;
      int kb;
      ka = 0;
      kb = 0;
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      for (int k = 1; k <= 200; k++) begin
         if (k < 90)
            drive(1'b0, 1'b1, 7'd3, {$urandom, $urandom}, '1, (k % 3) == 0, 7'(k));
         else
            drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
         if (a_init && ka == 0) ka = k;
         if (b_init && kb == 0) kb = k;
         if (ka != 0 && kb != 0) break;
      end
      check_eq("a_init_cycles", DW'(ka), DW'(DEPTH_A));
      check_eq("b_init_cycles", DW'(kb), DW'(DEPTH_B));
      for (int i = 0; i < DEPTH_A; i++) mem_a[i] = '0;
      for (int i = 0; i < DEPTH_B; i++) mem_b[i] = '0;
      rdy_a = 1'b1;
      rdy_b = 1'b1;
   endtask

   task automatic random_traffic(input int n);
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      for (int i = 0; i < n; i++) begin
         wa = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) ra = wa;
         drive(1'b0, 1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, 8'($urandom),
               1'($urandom_range(0, 1)), ra);
      end
   endtask

   // Scoreboard: every valid must match the head of the queue, in data and arrival cycle.
   always @(negedge clk) begin
      exp_t e;
      if (a_rd_vld) begin
         if (qa.size() == 0) begin
            check_eq("a_spurious_vld", DW'(1), DW'(0));
         end else begin
            e = qa.pop_front();
            check_eq("a_rd_data", a_rd_data, e.dat);
            check_eq("a_rd_cycle", DW'(cyc), DW'(e.due));
         end
      end else if (qa.size() > 0 && qa[0].due <= cyc) begin
         e = qa.pop_front();
         check_eq("a_missing_vld", DW'(0), DW'(1));
      end
      if (b_rd_vld) begin
         if (qb.size() == 0) begin
            check_eq("b_spurious_vld", DW'(1), DW'(0));
         end else begin
            e = qb.pop_front();
            check_eq("b_rd_data", b_rd_data, e.dat);
            check_eq("b_rd_cycle", DW'(cyc), DW'(e.due));
         end
      end else if (qb.size() > 0 && qb[0].due <= cyc) begin
         e = qb.pop_front();
         check_eq("b_missing_vld", DW'(0), DW'(1));
      end
   end

   initial begin
      // Reset state
      repeat (3) drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
      check_eq("a_rst_rd_data", a_rd_data, '0);
      check_eq("a_rst_rd_vld", DW'(a_rd_vld), '0);
      check_eq("a_rst_init", DW'(a_init), '0);
      check_eq("b_rst_rd_data", b_rd_data, '0);
      check_eq("b_rst_rd_vld", DW'(b_rd_vld), '0);
      check_eq("b_rst_init", DW'(b_init), '0);

      wait_init();

      // Every address reads back zero after the sweep, including the one hit during it
      for (int a = 0; a < 128; a++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'(a));
      idle(3);

      // Byte-enable write
      drive(1'b0, 1'b1, 7'd5, '1, '1, 1'b0, '0);
      drive(1'b0, 1'b1, 7'd5, '0, 8'h0F, 1'b0, '0);
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'd5);
      idle(3);

      // Back-to-back reads of 0..7
      for (int i = 0; i < 8; i++)
         drive(1'b0, 1'b1, 7'(i), {8{8'(8'h10 + i)}} ^ 64'h0123_4567_89AB_CDEF, '1, 1'b0, '0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'(i));
      idle(3);

      // Same-address collisions at 9, full and partial byte enables
      drive(1'b0, 1'b1, 7'd9, {8{8'hAA}}, '1, 1'b0, '0);
      idle(1);
      drive(1'b0, 1'b1, 7'd9, {8{8'h55}}, '1, 1'b1, 7'd9);
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'd9);
      drive(1'b0, 1'b1, 7'd9, {8{8'h33}}, 8'h0F, 1'b1, 7'd9);
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'd9);
      idle(3);

      // Out-of-range for the 100-deep instance, and its last legal address
      drive(1'b0, 1'b1, 7'd110, 64'h1234_5678_9ABC_DEF0, '1, 1'b0, '0);
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'd110);
      drive(1'b0, 1'b1, 7'd99, 64'hCAFE_F00D_DEAD_BEEF, '1, 1'b0, '0);
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'd99);
      idle(3);

      random_traffic(300);
      idle(4);

      // Reset while a read is in flight in the two-stage instance
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'd8);
      drive(1'b1, 1'b0, '0, '0, '0, 1'b1, 7'd9);
      drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);

      // Reset again at clear count 60, then the full sweep must rerun
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      repeat (59) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
      wait_init();

      for (int a = 0; a < 16; a++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'(a));
      for (int a = 96; a < 128; a++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 7'(a));
      idle(4);
      random_traffic(100);
      idle(5);

      check_eq("a_queue_drained", DW'(qa.size()), '0);
      check_eq("b_queue_drained", DW'(qb.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
